// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and arbitrates the single-port instruction RAM
// between fetch and a program loader. Define FETCH_PERF_CNT_EN to add stall/jump counters.
module imem_fetch_sequencer #(
    parameter int              AW       = 4,
    parameter logic [AW-1:0]   RESET_PC = 'd1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt,
    input  logic          stall,
    input  logic          jump,
    input  logic [AW-1:0] jp_address,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          ld_gnt,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    output logic          mem_en,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_4,
    output logic          fetch_valid,
    output logic [AW-1:0] fetch_pc,
    output logic [1:0]    busy_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   jump_cnt
`endif
);

    // state | meaning
    // IDLE  | after reset, waiting for loader or start
    // LOAD  | loader owns the RAM, one write per cycle
    // RUN   | fetching from pc
    // HALT  | fetch stopped, pc held for resume
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          ret_halt_q, ret_halt_d;
    logic          fetch_valid_q;
    logic [AW-1:0] fetch_pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ret_halt_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ret_halt_q    <= ret_halt_d;
            fetch_valid_q <= (state_q == S_RUN);
            fetch_pc_q    <= mem_addr;
        end
    end

    // RAM-side outputs depend on state only, so a write in a reset cycle still lands
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ret_halt_d = ret_halt_q;
        ld_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        mem_din    = '0;
        case (state_q)
            S_IDLE: begin
                if (ld_req) begin
                    state_d    = S_LOAD;
                    ret_halt_d = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_LOAD: begin
                ld_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_we   = ld_req;
                mem_addr = ld_addr;
                mem_din  = ld_data;
                if (!ld_req) begin
                    state_d = ret_halt_q ? S_HALT : S_IDLE;
                end
            end
            S_RUN: begin
                mem_en = 1'b1;
                if (halt) begin
                    state_d = S_HALT;
                end else if (jump) begin
                    pc_d = jp_address;
                end else if (!stall) begin
                    pc_d = pc_q + AW'(1);
                end
            end
            S_HALT: begin
                if (ld_req) begin
                    state_d    = S_LOAD;
                    ret_halt_d = 1'b1;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign pc_4        = pc_q + AW'(1);
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign busy_state  = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic        stall_hit, jump_hit;
    logic [15:0] stall_cnt_q, jump_cnt_q;

    assign stall_hit = (state_q == S_RUN) && stall && !jump && !halt;
    assign jump_hit  = (state_q == S_RUN) && jump && !halt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            jump_cnt_q  <= '0;
        end else begin
            if (stall_hit && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (jump_hit && (jump_cnt_q != 16'hFFFF))   jump_cnt_q  <= jump_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign jump_cnt  = jump_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Scoreboard bench for imem_fetch_sequencer: a cycle model predicts PC/arbiter outputs and
// queues expected fetches; a monitor pops them whenever fetch_valid is seen.
module tb_imem_fetch_sequencer;

    localparam int         DEPTH = 16;
    localparam logic [3:0] RPC   = 4'd1;
    localparam int IDLE = 0, LOAD = 1, RUN = 2, HALT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, start = 1'b0, halt = 1'b0, stall = 1'b0, jump = 1'b0, ld_req = 1'b0;
    logic [3:0]  jp_address = '0, ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_gnt, mem_we, mem_en, fetch_valid;
    logic [3:0]  mem_addr, pc, pc_4, fetch_pc;
    logic [31:0] mem_din;
    logic [1:0]  busy_state;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt, jump_cnt;
`endif

    imem_fetch_sequencer #(.AW(4), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall), .jump(jump),
        .jp_address(jp_address), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_gnt(ld_gnt), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_en(mem_en),
        .pc(pc), .pc_4(pc_4), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .busy_state(busy_state)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .jump_cnt(jump_cnt)
`endif
    );

    // Instruction RAM attached to the DUT's memory port, 1-cycle read latency
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_dout;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        ram_dout      <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [3:0]  pc;
        logic [31:0] data;
    } fetch_t;
    fetch_t sb[$];

    int tests = 0, fails = 0;

    // Reference model: m_* is the current cycle, n_* the cycle after the next edge
    logic [31:0] m_mem [DEPTH];
    int          m_state, n_state;
    logic [3:0]  m_pc, n_pc;
    bit          m_fv, n_fv, m_ret_halt, n_ret_halt;
    bit          m_known = 0, n_known = 0, m_post_rst, n_post_rst;
    int          m_scnt, n_scnt, m_jcnt, n_jcnt;
    bit          e_gnt, e_we, e_en;
    logic [3:0]  e_addr;
    logic [31:0] e_din;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(bit rst, bit st, bit hl, bit sl, bit jp, logic [3:0] ja,
                       bit lr, logic [3:0] la, logic [31:0] ld);
        @(posedge clk);
        #1;
        m_state = n_state; m_pc = n_pc; m_fv = n_fv; m_ret_halt = n_ret_halt;
        m_known = n_known; m_post_rst = n_post_rst; m_scnt = n_scnt; m_jcnt = n_jcnt;
        reset = rst; start = st; halt = hl; stall = sl; jump = jp; jp_address = ja;
        ld_req = lr; ld_addr = la; ld_data = ld;

        e_gnt  = (m_state == LOAD);
        e_en   = (m_state == LOAD) || (m_state == RUN);
        e_we   = (m_state == LOAD) && lr;
        e_addr = (m_state == LOAD) ? la : m_pc;
        e_din  = (m_state == LOAD) ? ld : 32'h0;

        n_state = m_state; n_pc = m_pc; n_ret_halt = m_ret_halt;
        n_fv = (m_state == RUN); n_post_rst = 0;
        n_scnt = m_scnt; n_jcnt = m_jcnt;
        if (m_known) begin
            if (m_state == IDLE) begin
                if (lr)      begin n_state = LOAD; n_ret_halt = 0; end
                else if (st) begin n_state = RUN; n_pc = RPC; end
            end else if (m_state == LOAD) begin
                if (lr) m_mem[la] = ld;
                else    n_state = m_ret_halt ? HALT : IDLE;
            end else if (m_state == RUN) begin
                if (rst) sb.push_back('{pc: m_pc, data: m_mem[m_pc]});
                if (hl) n_state = HALT;
                else if (jp) begin
                    n_pc = ja;
                    if (m_jcnt < 65535) n_jcnt = m_jcnt + 1;
                end else if (sl) begin
                    if (m_scnt < 65535) n_scnt = m_scnt + 1;
                end else n_pc = 4'((int'(m_pc) + 1) % DEPTH);
            end else begin
                if (lr)      begin n_state = LOAD; n_ret_halt = 1; end
                else if (st) n_state = RUN;
            end
        end
        if (!rst) begin
            n_state = IDLE; n_pc = RPC; n_fv = 0; n_ret_halt = 0;
            n_known = 1; n_post_rst = 1; n_scnt = 0; n_jcnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy_state", 32'(busy_state), 32'(m_state));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("pc_4", 32'(pc_4), 32'((int'(m_pc) + 1) % DEPTH));
            chk("ld_gnt", 32'(ld_gnt), 32'(e_gnt));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_din", mem_din, e_din);
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            if (m_post_rst) chk("fetch_pc_after_reset", 32'(fetch_pc), 32'(RPC));
`ifdef FETCH_PERF_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
            chk("jump_cnt", 32'(jump_cnt), 32'(m_jcnt));
`endif
            if (fetch_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL fetch_unexpected: got fetch_pc %h, expected no fetch", fetch_pc);
                end else begin
                    fetch_t f;
                    f = sb.pop_front();
                    chk("fetch_pc", 32'(fetch_pc), 32'(f.pc));
                    chk("fetch_data", ram_dout, f.data);
                end
            end
        end
    end

    task automatic idle_cyc(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
    endtask

    task automatic load_words(int n, logic [3:0] base, logic [31:0] d0);
        int idx;
        bit wrote;
        idx = 0;
        for (int g = 0; g < 4 * n + 4 && idx < n; g++) begin
            wrote = (n_state == LOAD);
            cyc(1, 0, 0, 0, 0, 4'd0, 1, base + 4'(idx), d0 + 32'(idx));
            if (wrote) idx++;
        end
        chk("load_words_done", 32'(idx), 32'(n));
        cyc(1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
    endtask

    task automatic run_to(logic [3:0] target);
        for (int g = 0; g < 40 && n_pc != target; g++) cyc(1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        chk("run_to_pc", 32'(n_pc), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i] = v;
            m_mem[i] = v;
        end
        ram_dout = '0;

        // start with no other input: pc walks 1..5
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        idle_cyc(5);

        // load A0..A2 from IDLE, then fetch them
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        load_words(3, 4'd0, 32'hA0);
        cyc(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        run_to(4'd3);

        // jump with stall at pc=3, then stall twice at pc=9
        cyc(1, 0, 0, 1, 1, 4'd9, 0, 4'd0, 32'h0);
        cyc(1, 0, 0, 1, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(1, 0, 0, 1, 0, 4'd0, 0, 4'd0, 32'h0);
        idle_cyc(1);

        // wrap from 14
        cyc(1, 0, 0, 0, 1, 4'd14, 0, 4'd0, 32'h0);
        idle_cyc(4);

        // halt at pc=6 with loader waiting, load in HALT, resume at 6
        cyc(1, 0, 0, 0, 1, 4'd6, 1, 4'd8, 32'h5555);
        cyc(1, 0, 1, 0, 0, 4'd0, 1, 4'd8, 32'h5555);
        cyc(1, 0, 0, 0, 0, 4'd0, 1, 4'd8, 32'h5555);
        cyc(1, 0, 0, 0, 0, 4'd0, 1, 4'd8, 32'h5555);
        cyc(1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        idle_cyc(3);

        // 3 stalls, 2 jumps, reset at pc=7
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 4'd0, 0, 4'd0, 32'h0);
        cyc(1, 0, 0, 0, 1, 4'd5, 0, 4'd0, 32'h0);
        cyc(1, 0, 0, 0, 1, 4'd6, 0, 4'd0, 32'h0);
        idle_cyc(1);
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        idle_cyc(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(39, 0) != 0,
                $urandom_range(99, 0) < 30,
                $urandom_range(99, 0) < 8,
                $urandom_range(99, 0) < 20,
                $urandom_range(99, 0) < 15,
                4'($urandom),
                $urandom_range(99, 0) < 25,
                4'($urandom),
                $urandom);
        end

        cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'h0);
        idle_cyc(2);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
